pc_sequencer: RTL and testbench

- Next-address controller for the 16-bit program counter register.
- Each cycle it selects the next PC from these sources: sequential, branch, jump, register-jump, hold, or exception vector.
- It drives the PC's data input and its enable.
- It records the exception PC and cause, and runs a small BOOT/RUN/STALL/EXC/HALT state machine that sequences fetch.
- It sits between the decode/branch logic and the PC register, in the single-cycle datapath.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_target_mux.sv | 39 +++
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds FSM state encodings, exception cause codes and the PC constants
// (width, sequential increment, exception/boot vector).
package pc_seq_pkg;

   localparam int PC_W = 16;

   // Sequential increment added to the PC.
   localparam logic [PC_W-1:0] INSTR_BYTES = 16'd2;

   // Exception/boot vector.
   // The PC register loads this value whenever pc_en is low.
   localparam logic [PC_W-1:0] EXC_VEC = 16'h0000;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STALL = 3'd2,
      ST_EXC   = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ILL   = 2'b01;
   localparam logic [1:0] CAUSE_MISAL = 2'b10;

endpackage

// File: rtl/pc_target_mux.sv
// Purpose : priority selection of the redirect target (jr > jump > branch) plus misaligned flag.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the selection is used.
// Ports   : i_jr/i_jump/i_branch_taken request flags with their targets;
//           o_redir = some redirect requested, o_target = chosen target,
//           o_misal = chosen target has bit0 set.
module pc_target_mux
   import pc_seq_pkg::*;
(
   input  logic            i_jr,
   input  logic [PC_W-1:0] i_jr_target,
   input  logic            i_jump,
   input  logic [PC_W-1:0] i_jump_target,
   input  logic            i_branch_taken,
   input  logic [PC_W-1:0] i_branch_target,
   output logic            o_redir,
   output logic [PC_W-1:0] o_target,
   output logic            o_misal
);

   always_comb begin
      o_redir  = 1'b0;
      o_target = '0;
      if (i_jr) begin
         o_redir  = 1'b1;
         o_target = i_jr_target;
      end else if (i_jump) begin
         o_redir  = 1'b1;
         o_target = i_jump_target;
      end else if (i_branch_taken) begin
         o_redir  = 1'b1;
         o_target = i_branch_target;
      end
      // Only a taken redirect can be misaligned.
      // Sequential fetch is never flagged.
      o_misal = o_redir & o_target[0];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose : next-PC controller with BOOT/RUN/STALL/EXC/HALT fetch FSM and epc/cause capture.
// Latency : outputs combinational from state+inputs; redirect visible on PC one cycle later.
// Backpressure: stall/halt hold the PC with pc_en=1 (pc_en=0 would vector to EXC_VEC).
// Ports   : clk, rst (sync, active-high); pc_cur; stall; branch/jump/jr requests and targets;
//           illegal_instr, halt_req, resume -> pc_next, pc_en, flush, epc, cause, state_o.
//           Optional exc_count[7:0] (saturating exception counter) when PC_SEQ_EXC_COUNT_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_cur,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   input  logic            illegal_instr,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc_next,
   output logic            pc_en,
   output logic            flush,
   output logic [PC_W-1:0] epc,
   output logic [1:0]      cause,
`ifdef PC_SEQ_EXC_COUNT_EN
   output logic [7:0]      exc_count,
`endif
   output logic [2:0]      state_o
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_epc;
   logic [1:0]      r_cause;

   logic            w_redir;
   logic [PC_W-1:0] w_target;
   logic            w_misal;
   logic            w_exc;
   logic [1:0]      w_exc_code;

   pc_target_mux u_target_mux (
      .i_jr            (jr),
      .i_jr_target     (jr_target),
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .o_redir         (w_redir),
      .o_target        (w_target),
      .o_misal         (w_misal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_BOOT;
         r_epc   <= '0;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_state_nxt;
         if (w_exc) begin
            r_epc   <= pc_cur;
            r_cause <= w_exc_code;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      pc_en       = 1'b1;
      pc_next     = pc_cur;
      flush       = 1'b0;
      w_exc       = 1'b0;
      w_exc_code  = CAUSE_NONE;

      case (r_state)
         ST_BOOT: begin
            pc_en       = 1'b0;
            pc_next     = EXC_VEC;
            flush       = 1'b1;
            w_state_nxt = ST_RUN;
         end

         ST_RUN: begin
            // A stalled instruction is not yet valid.
            // Its exception flags are therefore meaningless.
            if (!stall && (illegal_instr || w_misal)) begin
               w_exc       = 1'b1;
               w_exc_code  = illegal_instr ? CAUSE_ILL : CAUSE_MISAL;
               pc_en       = 1'b0;
               pc_next     = EXC_VEC;
               flush       = 1'b1;
               w_state_nxt = ST_EXC;
            end else if (!halt_req && stall) begin
               w_state_nxt = ST_STALL;
            end else begin
               // Normal advance.
               // This also covers the halt_req cycle, which still advances.
               pc_next = w_redir ? w_target : (pc_cur + INSTR_BYTES);
               if (halt_req) begin
                  w_state_nxt = ST_HALT;
               end
            end
         end

         ST_STALL: begin
            if (!stall) begin
               w_state_nxt = ST_RUN;
            end
         end

         ST_EXC: begin
            // The PC already holds EXC_VEC.
            // Spend one bubble cycle here.
            flush       = 1'b1;
            w_state_nxt = ST_RUN;
         end

         ST_HALT: begin
            if (resume) begin
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            pc_en       = 1'b0;
            pc_next     = EXC_VEC;
            flush       = 1'b1;
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

`ifdef PC_SEQ_EXC_COUNT_EN
   logic [7:0] r_exc_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exc_count <= 8'h00;
      end else if (w_exc && (r_exc_count != 8'hFF)) begin
         r_exc_count <= r_exc_count + 8'd1;
      end
   end

   assign exc_count = r_exc_count;
`endif

   assign epc     = r_epc;
   assign cause   = r_cause;
   assign state_o = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc_cur = 16'h0000;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic        jump = 1'b0;
   logic [15:0] jump_target = 16'h0000;
   logic        jr = 1'b0;
   logic [15:0] jr_target = 16'h0000;
   logic        illegal_instr = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [15:0] pc_next;
   logic        pc_en;
   logic        flush;
   logic [15:0] epc;
   logic [1:0]  cause;
   logic [2:0]  state_o;
`ifdef PC_SEQ_EXC_COUNT_EN
   logic [7:0]  exc_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .pc_cur        (pc_cur),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .illegal_instr (illegal_instr),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc_next       (pc_next),
      .pc_en         (pc_en),
      .flush         (flush),
      .epc           (epc),
      .cause         (cause),
`ifdef PC_SEQ_EXC_COUNT_EN
      .exc_count     (exc_count),
`endif
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   // Advance one clock edge.
   // Inputs are then driven 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      stall = 0; branch_taken = 0; jump = 0; jr = 0;
      illegal_instr = 0; halt_req = 0; resume = 0;
   endtask

   // Compare outputs against the expected values.
   // Outputs are sampled 2ns after the edge, once the combinational logic has settled.
   task automatic test_reset();
      rst = 1; clr_req(); pc_cur = 16'h0000;
      tick(); tick(); #1;
      n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
      n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got %b exp 0", pc_en); end
      n_checks++; if (pc_next !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_next got %h exp 0000", pc_next); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush got %b exp 1", flush); end
      n_checks++; if (epc !== 16'h0000 || cause !== 2'b00) begin n_fail++; $display("FAIL reset_epc_cause got %h/%b exp 0000/00", epc, cause); end
      rst = 0;
      tick(); #1;
      n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL boot_to_run got %0d exp 1", state_o); end
      n_checks++; if (pc_next !== 16'h0002 || pc_en !== 1'b1) begin n_fail++; $display("FAIL first_seq got %h/%b exp 0002/1", pc_next, pc_en); end
   endtask

   task automatic test_sequential();
      pc_cur = 16'hFFFE; #1;
      n_checks++; if (pc_next !== 16'h0000 || pc_en !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL seq_wrap got %h/%b/%b exp 0000/1/0", pc_next, pc_en, flush); end
      tick(); #1;
      n_checks++; if (state_o !== 3'd1 || cause !== 2'b00) begin n_fail++; $display("FAIL wrap_no_exc got %0d/%b exp 1/00", state_o, cause); end
      pc_cur = 16'h1234; #1;
      n_checks++; if (pc_next !== 16'h1236) begin n_fail++; $display("FAIL seq_1234 got %h exp 1236", pc_next); end
   endtask

   task automatic test_redirect();
      pc_cur = 16'h0010;
      branch_taken = 1; branch_target = 16'h0040;
      jump = 1; jump_target = 16'h0080; #1;
      n_checks++; if (pc_next !== 16'h0080 || pc_en !== 1'b1) begin n_fail++; $display("FAIL jump_over_branch got %h/%b exp 0080/1", pc_next, pc_en); end
      jr = 1; jr_target = 16'h0100; #1;
      n_checks++; if (pc_next !== 16'h0100) begin n_fail++; $display("FAIL jr_over_jump got %h exp 0100", pc_next); end
      jr = 0; jump = 0; #1;
      n_checks++; if (pc_next !== 16'h0040) begin n_fail++; $display("FAIL branch_only got %h exp 0040", pc_next); end
      tick(); clr_req(); #1;
      n_checks++; if (state_o !== 3'd1 || cause !== 2'b00) begin n_fail++; $display("FAIL redirect_no_exc got %0d/%b exp 1/00", state_o, cause); end
   endtask

   task automatic test_stall();
      pc_cur = 16'h0020; stall = 1; #1;
      n_checks++; if (pc_en !== 1'b1 || pc_next !== 16'h0020) begin n_fail++; $display("FAIL stall_c1 got %b/%h exp 1/0020", pc_en, pc_next); end
      tick(); illegal_instr = 1; #1;
      n_checks++; if (state_o !== 3'd2 || pc_en !== 1'b1 || pc_next !== 16'h0020 || flush !== 1'b0) begin n_fail++; $display("FAIL stall_c2 got %0d/%b/%h/%b exp 2/1/0020/0", state_o, pc_en, pc_next, flush); end
      tick(); illegal_instr = 0; #1;
      n_checks++; if (state_o !== 3'd2 || pc_en !== 1'b1 || pc_next !== 16'h0020) begin n_fail++; $display("FAIL stall_c3 got %0d/%b/%h exp 2/1/0020", state_o, pc_en, pc_next); end
      stall = 0;
      tick(); #1;
      n_checks++; if (state_o !== 3'd1 || pc_next !== 16'h0022 || cause !== 2'b00) begin n_fail++; $display("FAIL stall_release got %0d/%h/%b exp 1/0022/00", state_o, pc_next, cause); end
   endtask

   task automatic test_misaligned();
      pc_cur = 16'h0030; jr = 1; jr_target = 16'h0041; #1;
      n_checks++; if (pc_en !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL misal_detect got %b/%b exp 0/1", pc_en, flush); end
      tick(); clr_req(); pc_cur = 16'h0000; #1;
      n_checks++; if (state_o !== 3'd3 || epc !== 16'h0030 || cause !== 2'b10) begin n_fail++; $display("FAIL misal_capture got %0d/%h/%b exp 3/0030/10", state_o, epc, cause); end
      n_checks++; if (pc_en !== 1'b1 || flush !== 1'b1 || pc_next !== 16'h0000) begin n_fail++; $display("FAIL exc_bubble got %b/%b/%h exp 1/1/0000", pc_en, flush, pc_next); end
      tick(); #1;
      n_checks++; if (state_o !== 3'd1 || pc_next !== 16'h0002) begin n_fail++; $display("FAIL exc_to_run got %0d/%h exp 1/0002", state_o, pc_next); end
   endtask

   task automatic test_priority_halt();
      pc_cur = 16'h0050; illegal_instr = 1; halt_req = 1; #1;
      n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL ill_halt_detect got %b exp 0", pc_en); end
      tick(); clr_req(); pc_cur = 16'h0000; #1;
      n_checks++; if (state_o !== 3'd3 || cause !== 2'b01 || epc !== 16'h0050) begin n_fail++; $display("FAIL ill_over_halt got %0d/%b/%h exp 3/01/0050", state_o, cause, epc); end
      tick(); #1;
      n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL halt_dropped got %0d exp 1", state_o); end
      pc_cur = 16'h0060; halt_req = 1; #1;
      n_checks++; if (pc_next !== 16'h0062 || pc_en !== 1'b1) begin n_fail++; $display("FAIL halt_req_adv got %h/%b exp 0062/1", pc_next, pc_en); end
      tick(); halt_req = 0; pc_cur = 16'h0062;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (state_o !== 3'd4 || pc_next !== 16'h0062 || pc_en !== 1'b1) begin n_fail++; $display("FAIL halt_hold[%0d] got %0d/%h/%b exp 4/0062/1", i, state_o, pc_next, pc_en); end
         tick();
      end
      resume = 1; #1;
      n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL resume_cycle got %0d exp 4", state_o); end
      tick(); resume = 0; #1;
      n_checks++; if (state_o !== 3'd1 || pc_next !== 16'h0064) begin n_fail++; $display("FAIL resume_run got %0d/%h exp 1/0064", state_o, pc_next); end
   endtask

   task automatic test_reset_mid_halt();
      halt_req = 1; tick(); halt_req = 0; #1;
      n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL halt_again got %0d exp 4", state_o); end
      rst = 1; tick(); rst = 0; #1;
      n_checks++; if (state_o !== 3'd0 || epc !== 16'h0000 || cause !== 2'b00) begin n_fail++; $display("FAIL reset_in_halt got %0d/%h/%b exp 0/0000/00", state_o, epc, cause); end
      tick();
   endtask

`ifdef PC_SEQ_EXC_COUNT_EN
   task automatic test_exc_count();
      rst = 1; clr_req(); pc_cur = 16'h0000; tick(); rst = 0; #1;
      n_checks++; if (exc_count !== 8'h00) begin n_fail++; $display("FAIL cnt_reset got %h exp 00", exc_count); end
      tick();
      for (int i = 0; i < 256; i++) begin
         illegal_instr = 1; tick(); illegal_instr = 0; tick();
         if (i == 0) begin
            n_checks++; if (exc_count !== 8'h01) begin n_fail++; $display("FAIL cnt_one got %h exp 01", exc_count); end
         end
      end
      #1;
      n_checks++; if (exc_count !== 8'hFF) begin n_fail++; $display("FAIL cnt_sat got %h exp FF", exc_count); end
      rst = 1; tick(); rst = 0; #1;
      n_checks++; if (exc_count !== 8'h00) begin n_fail++; $display("FAIL cnt_rst got %h exp 00", exc_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_redirect();
      test_stall();
      test_misaligned();
      test_priority_halt();
      test_reset_mid_halt();
`ifdef PC_SEQ_EXC_COUNT_EN
      test_exc_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
